shared_dcache_arbiter_fsm: RTL
==============================

Name: shared_dcache_arbiter_fsm

Overview:
Sequential round-robin arbiter that shares the single shared data cache between processor0 and processor1. It selects one memory request per cycle, muxes that request's address, data and opcode to the cache, and gates each processor's enable. On a cache miss it holds the owner through a fixed refill penalty. It replaces the combinational arbiter, sitting between the two ARMS2 cores, sharedCache and arbiterMux.

Parameters:
MISS_PENALTY, 4, cycles spent in REFILL per miss (legal range 1..255)
LDUR_OP, 11'b11111000010, load opcode
STUR_OP, 11'b11111000000, store opcode

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
p0_opcode3  in  11  processor0 MEM-stage opcode
p1_opcode3  in  11  processor1 MEM-stage opcode
p0_address  in  64  processor0 data address
p1_address  in  64  processor1 data address
p0_data  in  64  processor0 store data
p1_data  in  64  processor1 store data
miss  in  1  sharedCache miss, combinational on address/opcode3
address  out  64  to sharedCache
data  out  64  to sharedCache
opcode3  out  11  to sharedCache; 11'b0 when no access
p0_enable  out  1  processor0 advance enable
p1_enable  out  1  processor1 advance enable
allowedAccess  out  1  to arbiterMux: 0 = p0 owns the cache, 1 = p1 owns it
cache_fill  out  1  one-cycle pulse: cache installs the line for address
busy  out  1  high while in REFILL

Behaviour:
- reqN = (pN_opcode3 == LDUR_OP) || (pN_opcode3 == STUR_OP). A non-memory processor is never stalled.
- Registered state: state {IDLE, REFILL}, owner (1b), last_grant (1b), cnt (8b).
- Reset (async, reset==0): state=IDLE, last_grant=1 (so p0 wins first), owner=0, cnt=0. While in reset and in IDLE with no request, the outputs are: address=0, data=0, opcode3=0, allowedAccess=0, p0_enable=1, p1_enable=1, cache_fill=0, busy=0.
- IDLE winner (combinational):
  - Only one requester: that requester wins.
  - Both request: winner = ~last_grant.
  - No requester: opcode3=0, address=0, data=0, allowedAccess=0, both enables=1, miss ignored.
- IDLE, winner present:
  - address, data and opcode3 come from the winner; allowedAccess=winner.
  - miss=0 (hit): winner enable=1; loser enable=~loser_req. At the edge, last_grant<=winner and state stays IDLE. Hit latency is zero extra cycles.
  - miss=1: both requesters have enable=0. At the edge, state<=REFILL, owner<=winner, cnt<=MISS_PENALTY-1.
- REFILL:
  - address, data and opcode3 are muxed from owner's inputs; allowedAccess=owner; busy=1.
  - Owner enable=0. Non-owner enable=~non-owner req, so a non-owner memory op waits.
  - miss is ignored in REFILL.
  - cnt!=0: cnt decrements each edge.
  - cnt==0 (final cycle): cache_fill=1 and owner enable=1, so the access retires this cycle with data from the filled line. At the edge, last_grant<=owner and state<=IDLE.
  - Total stall for a missing owner is MISS_PENALTY+1 cycles (detect cycle plus MISS_PENALTY REFILL cycles, retiring on the last).
- Fairness: a processor blocked by the other is granted next, provided it still requests. Back-to-back requests from both alternate p0,p1,p0,...
- Owner opcode leaving memory class during REFILL cannot happen, because the owner is stalled. The arbiter still completes REFILL regardless.
- Reset asserted mid-REFILL aborts immediately to the reset values. No cache_fill is issued.
- Within a cycle, enables are a function of state plus the current-cycle req/miss inputs. There are no combinational loops: miss depends only on address/opcode3.

Decomposition:
- Shared package arm_mem_pkg holds LDUR_OP, STUR_OP, NOP_OP (11'b0), the arb_state_t enum {IDLE, REFILL} and the grant encoding constants P0=1'b0, P1=1'b1.
- One sub-module, rr_pick2: a combinational 2-way round-robin picker (req0, req1, last_grant -> valid, winner). Everything else lives in shared_dcache_arbiter_fsm.

Test Plan:
1. Reset low then high; p0=LDUR @0x500 and p1=ADD, miss=0 -> same cycle address=0x500, opcode3=LDUR_OP, allowedAccess=0, p0_enable=1, p1_enable=1.
2. Both LDUR (p0 @0x500, p1 @0x580), miss=0, held for 4 cycles -> allowedAccess sequence 0,1,0,1. The loser's enable is 0 in each cycle and the winner's is 1.
3. p0 STUR @0x508, data 0xA, miss=1 for one cycle, MISS_PENALTY=4 -> busy=1 for 4 cycles, p0_enable=0 for 4 cycles. cache_fill=1 and p0_enable=1 on the 5th cycle; data output holds 0xA throughout.
4. During the test-3 refill, p1 issues LDUR @0x588 -> p1_enable=0 for the whole REFILL. p1 is granted (allowedAccess=1) in the first IDLE cycle after the fill.
5. During the test-3 refill, p1 issues ADD -> p1_enable stays 1 every cycle.
6. Assert reset at the 2nd REFILL cycle -> state returns to IDLE asynchronously, with busy=0, cache_fill=0, both enables=1. After release, both LDUR requests grant p0 first.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared memory-stage definitions for the dual-core data cache path.
// Opcodes, grant encoding and arbiter state type used by the arbiter and its picker.
package arm_mem_pkg;

  localparam logic [10:0] LDUR_OP = 11'b11111000010;
  localparam logic [10:0] STUR_OP = 11'b11111000000;
  localparam logic [10:0] NOP_OP  = 11'b00000000000;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } arb_state_t;

  function automatic logic is_mem_op(input logic [10:0] op);
    return (op == LDUR_OP) || (op == STUR_OP);
  endfunction

endpackage

// File: rtl/shared_dcache_arbiter_fsm_if.sv
// Processor/cache side bundle of the shared dcache arbiter.
// master = cores plus cache miss source, slave = arbiter.
interface shared_dcache_arbiter_fsm_if;

  logic [10:0] p0_opcode3;
  logic [10:0] p1_opcode3;
  logic [63:0] p0_address;
  logic [63:0] p1_address;
  logic [63:0] p0_data;
  logic [63:0] p1_data;
  logic        miss;

  logic [63:0] address;
  logic [63:0] data;
  logic [10:0] opcode3;
  logic        p0_enable;
  logic        p1_enable;
  logic        allowedAccess;
  logic        cache_fill;
  logic        busy;

  modport master (
    output p0_opcode3, p1_opcode3, p0_address, p1_address, p0_data, p1_data, miss,
    input  address, data, opcode3, p0_enable, p1_enable, allowedAccess, cache_fill, busy
  );

  modport slave (
    input  p0_opcode3, p1_opcode3, p0_address, p1_address, p0_data, p1_data, miss,
    output address, data, opcode3, p0_enable, p1_enable, allowedAccess, cache_fill, busy
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: zero latency, no backpressure.
// On contention the requester that did not win last time is chosen.
module rr_pick2
  import arm_mem_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic winner_o
);

  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = P0;
    if (req0_i && req1_i) begin
      winner_o = ~last_grant_i;
    end else if (req1_i) begin
      winner_o = P1;
    end
  end

endmodule

// File: rtl/shared_dcache_arbiter_fsm.sv
// Round-robin owner of the shared dcache: hits retire in the same cycle, a miss
// stalls the owner MISS_PENALTY+1 cycles; non-memory cores are never stalled.
module shared_dcache_arbiter_fsm
  import arm_mem_pkg::*;
#(
  parameter int MISS_PENALTY = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  shared_dcache_arbiter_fsm_if.slave  bus
);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] cnt_q, cnt_d;

  logic req0, req1;
  logic pick_vld, pick_winner;
  logic access, grant_sel;
  logic p0_en, p1_en, fill, busy;

  assign req0 = is_mem_op(bus.p0_opcode3);
  assign req1 = is_mem_op(bus.p1_opcode3);

  rr_pick2 u_pick (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_vld),
    .winner_o     (pick_winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= P0;
      last_grant_q <= P1;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    access       = 1'b0;
    grant_sel    = P0;
    p0_en        = 1'b1;
    p1_en        = 1'b1;
    fill         = 1'b0;
    busy         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          access    = 1'b1;
          grant_sel = pick_winner;
          if (!bus.miss) begin
            // Winner retires now; a losing memory op waits for its turn.
            p0_en        = (pick_winner == P0) ? 1'b1 : ~req0;
            p1_en        = (pick_winner == P1) ? 1'b1 : ~req1;
            last_grant_d = pick_winner;
          end else begin
            p0_en   = ~req0;
            p1_en   = ~req1;
            state_d = REFILL;
            owner_d = pick_winner;
            cnt_d   = 8'(MISS_PENALTY - 1);
          end
        end
      end

      REFILL: begin
        access    = 1'b1;
        grant_sel = owner_q;
        busy      = 1'b1;
        // The owner retires on the final refill cycle, reading the line being installed.
        p0_en     = (owner_q == P0) ? (cnt_q == 8'd0) : ~req0;
        p1_en     = (owner_q == P1) ? (cnt_q == 8'd0) : ~req1;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          fill         = 1'b1;
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.address       = 64'd0;
    bus.data          = 64'd0;
    bus.opcode3       = NOP_OP;
    bus.allowedAccess = P0;
    if (access) begin
      bus.address       = (grant_sel == P1) ? bus.p1_address : bus.p0_address;
      bus.data          = (grant_sel == P1) ? bus.p1_data    : bus.p0_data;
      bus.opcode3       = (grant_sel == P1) ? bus.p1_opcode3 : bus.p0_opcode3;
      bus.allowedAccess = grant_sel;
    end
  end

  assign bus.p0_enable  = p0_en;
  assign bus.p1_enable  = p1_en;
  assign bus.cache_fill = fill;
  assign bus.busy       = busy;

endmodule
